usb_rx_ctrl: RTL and testbench
==============================

USB_RX_CTRL -- requirements
Module: usb_rx_ctrl

Interface
REQ-001 SHALL have parameter SYNC_MIN, default 5: minimum count of decoded SYNC zeros before the SYNC terminating one is accepted.
REQ-002 SHALL have port CLK, input, 1: system clock; all state updates on rising edge.
REQ-003 SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port rx_en, input, 1: receiver enable; 0 forces IDLE on the next CLK edge.
REQ-005 SHALL have port sample, input, 1: one-CLK strobe per recovered bit period; all bit-level decisions are made only when sample=1.
REQ-006 SHALL have port se0, input, 1: line state is SE0 (both lines low).
REQ-007 SHALL have port dec_bit, input, 1: NRZI-decoded bit for the current bit period (1 = no transition).
REQ-008 SHALL have port stuffed, input, 1: current bit is a stuff bit and must be discarded.
REQ-009 SHALL have port stuff_err, input, 1: decoder bit-stuff violation flag.
REQ-010 SHALL have port shift_en, output, 1: enables decoder stuff tracking; 1 in SYNC, DATA, ERR.
REQ-011 SHALL have port rx_active, output, 1: packet in progress; 1 in DATA, ERR, EOP.
REQ-012 SHALL have port rx_valid, output, 1: one-CLK pulse, data_out holds a new byte.
REQ-013 SHALL have port rx_error, output, 1: one-CLK pulse on a detected receive error.
REQ-014 SHALL have port data_out, output, 8: last assembled byte, LSB received first.

Function
REQ-015 SHALL implement the states IDLE, SYNC, DATA, ERR and EOP, using a registered state variable.
REQ-016 IDLE: on sample with se0=0 and dec_bit=0, SHALL go to SYNC with zero_cnt=1; otherwise SHALL stay in IDLE.
REQ-017 SYNC, on sample with dec_bit=0: SHALL increment zero_cnt, saturating at 7.
REQ-018 SYNC, on sample with dec_bit=1: zero_cnt>=SYNC_MIN SHALL go to DATA with bit_cnt=0; zero_cnt<SYNC_MIN SHALL go to IDLE.
REQ-019 SYNC, on sample with se0=1: SHALL go to IDLE with no rx_error.
REQ-020 DATA, on sample with se0=0, stuff_err=0, stuffed=1: SHALL discard the bit, leaving shift register and bit_cnt unchanged.
REQ-021 DATA, on sample with se0=0, stuff_err=0, stuffed=0: SHALL set sr <= {dec_bit, sr[7:1]} and increment bit_cnt (3-bit, wraps 7->0).
REQ-022 When bit_cnt wraps 7->0, data_out SHALL load the completed byte and rx_valid SHALL pulse on the same CLK edge; latency is 1 CLK after the 8th data sample.
REQ-023 DATA, on sample with stuff_err=1 (priority over stuffed and dec_bit): SHALL go to ERR and pulse rx_error; stuff_err is checked before se0.
REQ-024 DATA, on sample with se0=1: SHALL go to EOP; if bit_cnt!=0 (partial byte), SHALL pulse rx_error and drop the partial byte with no rx_valid.
REQ-025 ERR: SHALL ignore data; on sample with se0=1, SHALL go to EOP with no further rx_error.
REQ-026 EOP: on sample with se0=0, SHALL go to IDLE; rx_active SHALL drop on the same edge.
REQ-027 rx_valid and rx_error SHALL each be registered, asserted for exactly 1 CLK per event, and never asserted in IDLE.
REQ-028 rx_en=0 in any state SHALL force IDLE, clear the counters and suppress rx_valid/rx_error on that edge; rx_en has priority over sample.
REQ-029 Between sample strobes, state, counters and outputs SHALL hold, except that the pulses return to 0.

Reset
REQ-030 While RST=0: state=IDLE, zero_cnt=0, bit_cnt=0, sr=0, data_out=8'h00, shift_en=0, rx_active=0, rx_valid=0, rx_error=0.
REQ-031 Assertion of RST mid-packet SHALL abort immediately with no rx_valid/rx_error pulse; after release, the block SHALL wait in IDLE for a new SYNC.

Verification
REQ-032 SHALL cover: decoded SYNC 0000000 then 1, data byte bits 1,0,1,0,0,1,0,1 LSB-first, then SE0 x2, then J -> one rx_valid with data_out=8'hA5, no rx_error, rx_active falls on the J sample.
REQ-033 SHALL cover: byte 8'hFF sent with a stuff bit (stuffed=1) after six ones -> stuff bit discarded, data_out=8'hFF, single rx_valid.
REQ-034 SHALL cover: stuff_err=1 during the 3rd data bit -> rx_error pulse, state ERR, no rx_valid, rx_active held until SE0 then J returns the block to IDLE.
REQ-035 SHALL cover: SE0 after 12 data bits -> one rx_valid (first byte), one rx_error (partial byte), then EOP->IDLE.
REQ-036 SHALL cover: SYNC with only 3 zeros then 1 -> back to IDLE, rx_active never set.
REQ-037 SHALL cover: rx_en=0, or RST=0, asserted mid-byte -> IDLE on the next edge, outputs at reset values, no pulses.

Source files
------------

// File: rtl/usb_rx_ctrl.sv
// USB receive packet controller: finds SYNC in the NRZI-decoded bit stream,
// assembles LSB-first bytes, and flags stuff violations and truncated bytes.
module usb_rx_ctrl #(
    parameter int SYNC_MIN = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_en,
    input  logic       sample,
    input  logic       se0,
    input  logic       dec_bit,
    input  logic       stuffed,
    input  logic       stuff_err,
    output logic       shift_en,
    output logic       rx_active,
    output logic       rx_valid,
    output logic       rx_error,
    output logic [7:0] data_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_DATA = 3'd2,
        S_ERR  = 3'd3,
        S_EOP  = 3'd4
    } state_t;

    localparam logic [2:0] SYNC_MIN_W = 3'(SYNC_MIN);

    state_t     state_q, state_d;
    logic [2:0] zero_cnt_q, zero_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            zero_cnt_q <= 3'd0;
            bit_cnt_q  <= 3'd0;
            sr_q       <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            zero_cnt_q <= zero_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic: rx_en overrides everything, otherwise only sample edges advance.
    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = S_IDLE;
        end else if (sample) begin
            case (state_q)
                S_IDLE: if (!se0 && !dec_bit) state_d = S_SYNC;
                S_SYNC: begin
                    if (se0)
                        state_d = S_IDLE;
                    else if (dec_bit)
                        state_d = (zero_cnt_q >= SYNC_MIN_W) ? S_DATA : S_IDLE;
                end
                S_DATA: begin
                    if (stuff_err)
                        state_d = S_ERR;
                    else if (se0)
                        state_d = S_EOP;
                end
                S_ERR:  if (se0) state_d = S_EOP;
                S_EOP:  if (!se0) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        zero_cnt_d = zero_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        if (!rx_en) begin
            zero_cnt_d = 3'd0;
            bit_cnt_d  = 3'd0;
            sr_d       = 8'h00;
            data_d     = 8'h00;
        end else if (sample) begin
            case (state_q)
                S_IDLE: if (!se0 && !dec_bit) zero_cnt_d = 3'd1;
                S_SYNC: begin
                    if (se0) begin
                        zero_cnt_d = 3'd0;
                    end else if (!dec_bit) begin
                        if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
                    end else begin
                        zero_cnt_d = 3'd0;
                        bit_cnt_d  = 3'd0;
                    end
                end
                S_DATA: begin
                    if (stuff_err) begin
                        error_d = 1'b1;
                    end else if (se0) begin
                        // A byte boundary at SE0 is a clean end; anything else is truncated.
                        error_d   = (bit_cnt_q != 3'd0);
                        bit_cnt_d = 3'd0;
                    end else if (!stuffed) begin
                        sr_d      = {dec_bit, sr_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            data_d  = {dec_bit, sr_q[7:1]};
                            valid_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        shift_en  = 1'b0;
        rx_active = 1'b0;
        case (state_q)
            S_SYNC: shift_en = 1'b1;
            S_DATA: begin shift_en = 1'b1; rx_active = 1'b1; end
            S_ERR:  begin shift_en = 1'b1; rx_active = 1'b1; end
            S_EOP:  rx_active = 1'b1;
            default: ;
        endcase
    end

    assign rx_valid = valid_q;
    assign rx_error = error_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Bench for usb_rx_ctrl: directed packet scenarios plus randomized packets,
// all checked every cycle against a bit-queue model of the receiver.
module tb_usb_rx_ctrl;
    localparam int SYNC_MIN = 5;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rx_en = 1'b0, sample = 1'b0, se0 = 1'b0, dec_bit = 1'b1;
    logic       stuffed = 1'b0, stuff_err = 1'b0;
    logic       shift_en, rx_active, rx_valid, rx_error;
    logic [7:0] data_out;

    usb_rx_ctrl #(.SYNC_MIN(SYNC_MIN)) dut (
        .CLK(CLK), .RST(RST), .rx_en(rx_en), .sample(sample), .se0(se0),
        .dec_bit(dec_bit), .stuffed(stuffed), .stuff_err(stuff_err),
        .shift_en(shift_en), .rx_active(rx_active), .rx_valid(rx_valid),
        .rx_error(rx_error), .data_out(data_out)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_err = 0, cyc = 0;
    int dv_cnt = 0, de_cnt = 0, act_seen = 0;
    bit chk_on = 0;

    // Model: zeros seen while hunting SYNC (0 = not hunting), packet flags, bit queue.
    int       m_zeros = 0;
    bit       m_pkt = 0, m_bad = 0, m_eop = 0;
    bit       m_q[$];
    logic [7:0] e_data = 8'h00;
    bit       e_valid = 0, e_err = 0;

    function automatic void model_reset();
        m_zeros = 0; m_pkt = 0; m_bad = 0; m_eop = 0; m_q.delete();
        e_data = 8'h00; e_valid = 0; e_err = 0;
    endfunction

    function automatic void model_update(bit en, bit smp, bit s0, bit db, bit stf, bit serr);
        logic [7:0] b;
        e_valid = 0; e_err = 0;
        if (!en) begin model_reset(); return; end
        if (!smp) return;
        if (m_zeros > 0) begin
            if (s0) m_zeros = 0;
            else if (!db) m_zeros++;
            else begin
                if (m_zeros >= SYNC_MIN) begin m_pkt = 1; m_q.delete(); end
                m_zeros = 0;
            end
        end else if (m_pkt) begin
            if (serr) begin m_pkt = 0; m_bad = 1; e_err = 1; end
            else if (s0) begin
                m_pkt = 0; m_eop = 1;
                e_err = (m_q.size() != 0);
                m_q.delete();
            end else if (!stf) begin
                m_q.push_back(db);
                if (m_q.size() == 8) begin
                    for (int i = 0; i < 8; i++) b[i] = m_q[i];
                    e_data = b; e_valid = 1; m_q.delete();
                end
            end
        end else if (m_bad) begin
            if (s0) begin m_bad = 0; m_eop = 1; end
        end else if (m_eop) begin
            if (!s0) m_eop = 0;
        end else if (!s0 && !db) begin
            m_zeros = 1;
        end
    endfunction

    always @(negedge CLK) begin
        logic [11:0] act, exp;
        cyc++;
        if (chk_on) begin
            act = {shift_en, rx_active, rx_valid, rx_error, data_out};
            exp = {(m_zeros > 0) || m_pkt || m_bad, m_pkt || m_bad || m_eop, e_valid, e_err, e_data};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL cycle %0d: {shift_en,rx_active,rx_valid,rx_error,data_out} got %03h expected %03h",
                         cyc, act, exp);
            end
            if (rx_valid) dv_cnt++;
            if (rx_error) de_cnt++;
            if (rx_active) act_seen++;
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit en, input bit smp, input bit s0, input bit db, input bit stf, input bit serr);
        rx_en = en; sample = smp; se0 = s0; dec_bit = db; stuffed = stf; stuff_err = serr;
        @(posedge CLK);
        if (RST) model_update(en, smp, s0, db, stf, serr);
        @(negedge CLK);
    endtask

    // One bit period: a sample strobe followed by 0-2 idle clocks of random line noise.
    task automatic bitp(input bit s0, input bit db, input bit stf, input bit serr);
        int gap;
        step(1, 1, s0, db, stf, serr);
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++)
            step(1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic send_sync(input int nz);
        for (int i = 0; i < nz; i++) bitp(0, 0, 0, 0);
        bitp(0, 1, 0, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) bitp(0, b[i], 0, 0);
    endtask

    task automatic send_eop();
        bitp(1, 0, 0, 0);
        bitp(1, 0, 0, 0);
        bitp(0, 1, 0, 0);
    endtask

    initial begin
        int dv0, de0, nb;
        step(0, 0, 0, 1, 0, 0);
        chk_on = 1;
        step(0, 0, 0, 1, 0, 0);
        check_lit("reset_outputs", {shift_en, rx_active, rx_valid, rx_error, data_out}, 0);
        @(negedge CLK);
        RST = 1'b1;
        step(1, 0, 0, 1, 0, 0);

        // Clean 0xA5 packet
        dv0 = dv_cnt; de0 = de_cnt;
        send_sync(7);
        for (int i = 0; i < 8; i++) bitp(0, (8'hA5 >> i) & 1, 0, 0);
        send_eop();
        check_lit("a5_data", data_out, 8'hA5);
        check_lit("a5_valid_cnt", dv_cnt - dv0, 1);
        check_lit("a5_error_cnt", de_cnt - de0, 0);
        check_lit("a5_idle_after_j", rx_active, 0);

        // 0xFF with a stuff bit after six ones
        dv0 = dv_cnt; de0 = de_cnt;
        send_sync(6);
        for (int i = 0; i < 6; i++) bitp(0, 1, 0, 0);
        bitp(0, 0, 1, 0);
        bitp(0, 1, 0, 0);
        bitp(0, 1, 0, 0);
        send_eop();
        check_lit("ff_data", data_out, 8'hFF);
        check_lit("ff_valid_cnt", dv_cnt - dv0, 1);

        // Stuff error on the third data bit
        dv0 = dv_cnt; de0 = de_cnt;
        send_sync(7);
        bitp(0, 1, 0, 0);
        bitp(0, 0, 0, 0);
        bitp(0, 1, 0, 1);
        check_lit("serr_active_held", rx_active, 1);
        for (int i = 0; i < 6; i++) bitp(0, 1'($urandom), 0, 0);
        check_lit("serr_active_still", rx_active, 1);
        send_eop();
        check_lit("serr_error_cnt", de_cnt - de0, 1);
        check_lit("serr_valid_cnt", dv_cnt - dv0, 0);

        // SE0 after 12 data bits: one byte, then a truncated one
        dv0 = dv_cnt; de0 = de_cnt;
        send_sync(7);
        send_byte(8'h3C);
        for (int i = 0; i < 4; i++) bitp(0, 1'(i), 0, 0);
        send_eop();
        check_lit("part_data", data_out, 8'h3C);
        check_lit("part_valid_cnt", dv_cnt - dv0, 1);
        check_lit("part_error_cnt", de_cnt - de0, 1);

        // Short SYNC never opens a packet
        dv0 = dv_cnt; de0 = de_cnt; act_seen = 0;
        send_sync(3);
        send_byte(8'h5A);
        send_eop();
        check_lit("short_sync_active", act_seen, 0);
        check_lit("short_sync_pulses", dv_cnt - dv0 + de_cnt - de0, 0);

        // rx_en drop mid-byte
        dv0 = dv_cnt; de0 = de_cnt;
        send_sync(7);
        for (int i = 0; i < 3; i++) bitp(0, 1, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        check_lit("rxen_outputs", {shift_en, rx_active, rx_valid, rx_error, data_out}, 0);
        step(1, 0, 0, 1, 0, 0);

        // Asynchronous reset mid-byte
        send_sync(7);
        send_byte(8'h81);
        for (int i = 0; i < 4; i++) bitp(0, 0, 0, 0);
        #2 RST = 1'b0;
        model_reset();
        #1 check_lit("rst_async_outputs", {shift_en, rx_active, rx_valid, rx_error, data_out}, 0);
        step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        RST = 1'b1;
        for (int i = 0; i < 4; i++) bitp(0, 0, 0, 0);
        check_lit("rst_no_pulses", dv_cnt - dv0 + de_cnt - de0, 1);
        check_lit("rst_no_packet", rx_active, 0);
        bitp(0, 1, 0, 0);

        // Randomized line noise
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 63) != 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                 1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));

        // Randomized packets with occasional faults
        for (int p = 0; p < 60; p++) begin
            send_sync($urandom_range(2, 8));
            nb = $urandom_range(0, 24);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 99) == 0)
                    step(0, 1, 0, 1'($urandom), 0, 0);
                else
                    bitp(0, 1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
            end
            send_eop();
            for (int i = 0; i < $urandom_range(0, 3); i++) bitp(0, 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end
endmodule
